score_tracker: RTL
==================

# score_tracker

Game-side producer of the score values consumed by the on-screen score and hi-score drawers. Counts the running score from a per-frame tick, latches the hi score at game over, and keeps both values available as 32-bit binary words and as 4-digit BCD. The BCD digits come from one shared sequential shift-add-3 converter, so the drawers need no divide/modulo logic. Sits between the game-control FSM and the score/hi-score display blocks.

## Interface
Parameters:
- MAX_SCORE, 9999: saturation value; must fit in 14 bits and in 4 BCD digits.
- TICKS_PER_POINT, 6: score ticks per point increment; range 1..63.

Ports:
- clk  in  1  pixel/system clock; single clock domain.
- rst_n  in  1  reset; synchronous, active-low.
- tick  in  1  one-cycle score-tick pulse (per frame).
- start  in  1  one-cycle pulse; begins a new run.
- game_over  in  1  one-cycle pulse; ends the current run.
- running  out  1  high in state RUN.
- score  out  32  current score, binary, zero-extended from 14 bits.
- score_hi  out  32  hi score, binary, zero-extended from 14 bits.
- score_bcd  out  16  current score digits {thou,hund,ten,unit}.
- hi_bcd  out  16  hi score digits {thou,hund,ten,unit}.
- bcd_busy  out  1  converter active, or a conversion is pending.

## Operation
- Game FSM states: IDLE, RUN, OVER. Reset enters IDLE.
  - IDLE/OVER + start: clear score and the tick prescaler; go to RUN.
  - RUN + game_over: go to OVER. In the same edge, score_hi <= max(score_hi, score).
  - RUN + start: restart. Score and the prescaler clear, and the state stays RUN.
  - start and game_over in the same cycle: game_over wins in RUN; start wins in IDLE/OVER.
  - game_over outside RUN: ignored.
- Scoring (RUN only):
  - The prescaler counts ticks from 0 to TICKS_PER_POINT-1 and wraps.
  - On the wrap, score increments by 1, saturating at MAX_SCORE. The prescaler keeps wrapping at saturation.
  - A tick arriving in the same cycle as game_over is dropped.
- score_hi is only ever written at game over and only grows. Only rst_n clears it.
- Conversion scheduler: two dirty flags, dirty_s and dirty_h.
  - A flag is set on any cycle its binary value changes.
  - When the converter is idle and a flag is set, issue start with a snapshot of that value and clear the flag.
  - If the flag is re-set in that same cycle, the set wins.
  - If both flags are set, serve the one not served last (round-robin, initial preference: score).
- Converter result: score_bcd/hi_bcd update only when the converter returns. All 16 bits update at once, and each result goes to the register matching the snapshot source.
- bcd_busy = converter busy | dirty_s | dirty_h.

## Timing
- Reset values: state IDLE, running 0, score 0, score_hi 0, score_bcd 16'h0000, hi_bcd 16'h0000, bcd_busy 0, prescaler 0, both dirty flags 0, round-robin pointer set to score.
- rst_n low on any edge aborts an in-flight conversion. The result is discarded and all registers return to reset values.
- score and running are registered: visible the cycle after the causing tick/start/game_over edge.
- Converter latency:
  - Cycle N: the scheduler issues start.
  - Cycles N+1..N+14: 14 shift iterations.
  - Cycle N+15: done pulse; the top-level latches bcd.
  - N+16: new BCD visible.
- Worst case, both pending: 32 cycles from the second flag set to hi_bcd valid. Far below one frame, so the BCD lags binary by at most two conversions.
- A score change during a conversion does not corrupt it. The snapshot is converted, dirty_s re-sets, and a second conversion follows.

## Structure
- Shared package/header holds:
  - FSM state encodings: IDLE=2'd0, RUN=2'd1, OVER=2'd2.
  - Score width SCORE_W=14.
  - BCD width BCD_W=16.
- Sub-module bin2bcd_seq.
  - Ports: clk, rst_n, start, bin[13:0], busy, done, bcd[15:0].
  - Double-dabble with a 30-bit shift register and a 4-bit iteration counter.
  - Add 3 to every nibble ≥5 before each shift.
  - start while busy is ignored.
- score_tracker holds the game FSM, prescaler, score registers, scheduler and output registers. Around 200 lines total RTL.

## Test plan
- Reset, then start, then 6×9 ticks: score=9; score_bcd=16'h0009 within 16 cycles after the last change; running=1.
- Preload via ticks to 9998, then 12 more points' worth of ticks: score saturates at 9999, score_bcd=16'h9999, no wrap to 0.
- Run to score 1234, pulse game_over: score_hi=1234, hi_bcd=16'h1234. Restart and reach 57, game_over: score_hi stays 1234.
- tick on the point boundary together with game_over at score 41: score stays 41, state OVER, score_hi=41 when the previous hi was lower.
- Score change on every cycle of a conversion: bcd_busy stays high. The final score_bcd equals the final binary score within 32 cycles after the changes stop, and hi_bcd is never starved.
- rst_n low mid-conversion at score 500: next cycle all outputs are 0, bcd_busy=0, and no late done updates score_bcd.

Source files
------------

// File: rtl/score_tracker_pkg.sv
// score_tracker_pkg: shared widths and game FSM state encoding for the score tracker
package score_tracker_pkg;
  localparam int SCORE_W = 14;
  localparam int BCD_W = 16;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, OVER = 2'd2} state_t;
endpackage

// File: rtl/bin2bcd_seq.sv
// bin2bcd_seq: sequential double-dabble converter, 14-bit binary to 4 BCD digits in 14 shifts
// ports: clk, rst_n (sync, active-low), start (ignored while busy), bin, busy (shifting or done), done (1-cycle), bcd (valid with done)
module bin2bcd_seq
  import score_tracker_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic [SCORE_W-1:0] bin,
  output logic               busy,
  output logic               done,
  output logic [BCD_W-1:0]   bcd
);
  localparam int SR_W = SCORE_W + BCD_W;
  localparam logic [3:0] LAST = 4'(SCORE_W - 1);
  logic [SR_W-1:0] sr_q, sr_d, adj;
  logic [3:0] cnt_q, cnt_d;
  logic busy_q, busy_d, done_q, done_d, start_ok;
  always_comb begin
    adj = sr_q;
    for (int i = 0; i < 4; i++)
      adj[SCORE_W+4*i +: 4] = (sr_q[SCORE_W+4*i +: 4] >= 4'd5) ? sr_q[SCORE_W+4*i +: 4] + 4'd3 : sr_q[SCORE_W+4*i +: 4];
    start_ok = start & ~busy_q & ~done_q;
    sr_d = start_ok ? {{BCD_W{1'b0}}, bin} : busy_q ? adj << 1 : sr_q;
    cnt_d = start_ok ? 4'd0 : busy_q ? cnt_q + 4'd1 : cnt_q;
    busy_d = start_ok | (busy_q & (cnt_q != LAST));
    done_d = busy_q & (cnt_q == LAST);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sr_q <= '0;
      cnt_q <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      sr_q <= sr_d;
      cnt_q <= cnt_d;
      busy_q <= busy_d;
      done_q <= done_d;
    end
  end
  // done counts as busy so a new start cannot overwrite the result being latched
  assign busy = busy_q | done_q;
  assign done = done_q;
  assign bcd = sr_q[SR_W-1 -: BCD_W];
endmodule

// File: rtl/score_tracker.sv
// score_tracker: game FSM, tick-prescaled saturating score, hi score latch and shared BCD conversion scheduler
// ports: clk, rst_n (sync, active-low), tick/start/game_over pulses in; running, score, score_hi (32b binary),
//        score_bcd, hi_bcd (4 BCD digits), bcd_busy (conversion running or pending) out
module score_tracker
  import score_tracker_pkg::*;
#(
  parameter int MAX_SCORE = 9999,
  parameter int TICKS_PER_POINT = 6
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tick,
  input  logic        start,
  input  logic        game_over,
  output logic        running,
  output logic [31:0] score,
  output logic [31:0] score_hi,
  output logic [15:0] score_bcd,
  output logic [15:0] hi_bcd,
  output logic        bcd_busy
);
  localparam logic [SCORE_W-1:0] MAX = SCORE_W'(MAX_SCORE);
  localparam logic [5:0] TLAST = 6'(TICKS_PER_POINT - 1);
  state_t state_q, state_d;
  logic [5:0] presc_q, presc_d;
  logic [SCORE_W-1:0] score_q, score_d, hi_q, hi_d, conv_bin;
  logic [BCD_W-1:0] score_bcd_q, score_bcd_d, hi_bcd_q, hi_bcd_d, conv_bcd;
  logic dirty_s_q, dirty_s_d, dirty_h_q, dirty_h_d, pref_h_q, pref_h_d, src_q, src_d;
  logic go, st, adv, wrap, issue, pick_h, conv_busy, conv_done;
  always_comb begin
    go = game_over & (state_q == RUN);
    st = start & ~go;
    adv = (state_q == RUN) & tick & ~game_over & ~start;
    wrap = adv & (presc_q == TLAST);
    state_d = go ? OVER : st ? RUN : state_q;
    presc_d = (st | wrap) ? 6'd0 : adv ? presc_q + 6'd1 : presc_q;
    score_d = st ? '0 : (wrap && score_q != MAX) ? score_q + 1'b1 : score_q;
    hi_d = (go && score_q > hi_q) ? score_q : hi_q;
    issue = ~conv_busy & (dirty_s_q | dirty_h_q);
    // pref_h_q remembers that score was served last, so hi goes next when both wait
    pick_h = dirty_h_q & (~dirty_s_q | pref_h_q);
    conv_bin = pick_h ? hi_q : score_q;
    dirty_s_d = (score_d != score_q) | (dirty_s_q & ~(issue & ~pick_h));
    dirty_h_d = (hi_d != hi_q) | (dirty_h_q & ~(issue & pick_h));
    pref_h_d = issue ? ~pick_h : pref_h_q;
    src_d = issue ? pick_h : src_q;
    score_bcd_d = (conv_done & ~src_q) ? conv_bcd : score_bcd_q;
    hi_bcd_d = (conv_done & src_q) ? conv_bcd : hi_bcd_q;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      presc_q <= '0;
      score_q <= '0;
      hi_q <= '0;
      score_bcd_q <= '0;
      hi_bcd_q <= '0;
      dirty_s_q <= 1'b0;
      dirty_h_q <= 1'b0;
      pref_h_q <= 1'b0;
      src_q <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      score_q <= score_d;
      hi_q <= hi_d;
      score_bcd_q <= score_bcd_d;
      hi_bcd_q <= hi_bcd_d;
      dirty_s_q <= dirty_s_d;
      dirty_h_q <= dirty_h_d;
      pref_h_q <= pref_h_d;
      src_q <= src_d;
    end
  end
  bin2bcd_seq u_conv (
    .clk  (clk),
    .rst_n(rst_n),
    .start(issue),
    .bin  (conv_bin),
    .busy (conv_busy),
    .done (conv_done),
    .bcd  (conv_bcd)
  );
  assign running = state_q == RUN;
  assign score = {{(32-SCORE_W){1'b0}}, score_q};
  assign score_hi = {{(32-SCORE_W){1'b0}}, hi_q};
  assign score_bcd = score_bcd_q;
  assign hi_bcd = hi_bcd_q;
  assign bcd_busy = conv_busy | dirty_s_q | dirty_h_q;
endmodule
